// File: rtl/reg_demux_pkg.sv
// reg_demux_pkg
//   Shared types for the register-bus target-side demultiplexer.
//   - state_e     : FSM states of reg_demux_cut (IDLE, FWD, RESP)
//   - reg_req_t   : default register-bus request (32-bit addr/data)
//   - reg_rsp_t   : default register-bus response (32-bit data)
//   - cnt_width() : width of the FWD stall counter for a given timeout
package reg_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  // Enough bits to hold the value timeout_cycles; never narrower than one
  // bit so a disabled timeout (0) still yields a legal counter.
  function automatic int cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_addr_decode.sv
// reg_addr_decode
//   Combinational base/mask address decoder, first match wins.
//   Ports:
//     addr  in   AW            address to decode
//     base  in   NoPorts x AW  per-port base address
//     mask  in   NoPorts x AW  per-port compare mask
//     hit   out  1             at least one port matched
//     idx   out  IW            lowest matching port index (0 on miss)
module reg_addr_decode #(
  parameter int NoPorts = 4,
  parameter int AW      = 32,
  localparam int IW     = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
  input  logic [AW-1:0]              addr,
  input  logic [NoPorts-1:0][AW-1:0] base,
  input  logic [NoPorts-1:0][AW-1:0] mask,
  output logic                       hit,
  output logic [IW-1:0]              idx
);

  // Scan from the highest index down so the last assignment, and therefore
  // the result, belongs to the lowest matching port.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NoPorts - 1; i >= 0; i--) begin
      if ((addr & mask[i]) == (base[i] & mask[i])) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/reg_demux_cut.sv
// reg_demux_cut
//   Routes one register-bus initiator to NoPorts targets through a full
//   register cut. A request is latched and decoded in IDLE, forwarded to the
//   selected target in FWD, and the captured response is returned in RESP.
//   Unmapped addresses and stalled targets are answered with error = 1.
//   Ports:
//     clk_i        in   1              clock
//     rst_i        in   1              asynchronous active-high reset
//     addr_base_i  in   NoPorts x AW   per-port base address
//     addr_mask_i  in   NoPorts x AW   per-port compare mask
//     in_req_i     in   req_t          initiator request
//     in_rsp_o     out  rsp_t          initiator response
//     out_req_o    out  NoPorts x req_t target requests
//     out_rsp_i    in   NoPorts x rsp_t target responses
//     busy_o       out  1              state is not IDLE
//     timeout_o    out  1              one-cycle pulse on a timeout abort
module reg_demux_cut
  import reg_demux_pkg::*;
#(
  parameter int  NoPorts       = 4,
  parameter int  AW            = 32,
  parameter int  DW            = 32,
  parameter type req_t         = reg_req_t,
  parameter type rsp_t         = reg_rsp_t,
  parameter int  TimeoutCycles = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NoPorts-1:0][AW-1:0] addr_base_i,
  input  logic [NoPorts-1:0][AW-1:0] addr_mask_i,
  input  req_t                       in_req_i,
  output rsp_t                       in_rsp_o,
  output req_t [NoPorts-1:0]         out_req_o,
  input  rsp_t [NoPorts-1:0]         out_rsp_i,
  output logic                       busy_o,
  output logic                       timeout_o
);

  localparam int IW = (NoPorts > 1) ? $clog2(NoPorts) : 1;
  localparam int SW = DW / 8;
  localparam int CW = cnt_width(TimeoutCycles);

  localparam bit            TimeoutEn = (TimeoutCycles != 0);
  localparam logic [CW-1:0] CntLast   = TimeoutEn ? CW'(TimeoutCycles - 1) : '0;
  localparam logic [CW-1:0] CntMax    = '1;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [IW-1:0]   sel_q;
  logic [DW-1:0]   rdata_q;
  logic            error_q;
  logic [CW-1:0]   cnt_q;
  logic            timeout_q;

  logic            dec_hit;
  logic [IW-1:0]   dec_idx;

  // Decode straight from the live request so the hit/miss decision is made
  // in the same IDLE cycle the request is latched.
  reg_addr_decode #(
    .NoPorts (NoPorts),
    .AW      (AW)
  ) u_decode (
    .addr (in_req_i.addr),
    .base (addr_base_i),
    .mask (addr_mask_i),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Single FSM process owning every register. A target handshake in the
  // last allowed FWD cycle wins over the timeout. The timeout flag is
  // registered on the abort edge, so it is high during the RESP cycle only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (in_req_i.valid) begin
            addr_q  <= in_req_i.addr;
            write_q <= in_req_i.write;
            wdata_q <= in_req_i.wdata;
            wstrb_q <= in_req_i.wstrb;
            rdata_q <= '0;
            if (dec_hit) begin
              sel_q   <= dec_idx;
              error_q <= 1'b0;
              state_q <= FWD;
            end else begin
              error_q <= 1'b1;
              state_q <= RESP;
            end
          end
        end

        FWD: begin
          if (out_rsp_i[sel_q].ready) begin
            rdata_q <= out_rsp_i[sel_q].rdata;
            error_q <= out_rsp_i[sel_q].error;
            state_q <= RESP;
          end else if (TimeoutEn && (cnt_q == CntLast)) begin
            rdata_q   <= '0;
            error_q   <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= RESP;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        RESP: begin
          timeout_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Every target sees the latched fields; only the selected one sees valid,
  // and only while the request is being forwarded.
  always_comb begin
    for (int i = 0; i < NoPorts; i++) begin
      out_req_o[i]       = '0;
      out_req_o[i].addr  = addr_q;
      out_req_o[i].write = write_q;
      out_req_o[i].wdata = wdata_q;
      out_req_o[i].wstrb = wstrb_q;
      out_req_o[i].valid = (state_q == FWD) && (sel_q == IW'(i));
    end
  end

  // The initiator response is driven only from RESP; all other states
  // return zeros so stale data never leaks out.
  always_comb begin
    in_rsp_o = '0;
    if (state_q == RESP) begin
      in_rsp_o.ready = 1'b1;
      in_rsp_o.rdata = rdata_q;
      in_rsp_o.error = error_q;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign timeout_o = timeout_q;

endmodule
